// File: rtl/wb_regfile.sv
// Write-back stage: decodes the W-stage instruction, selects/extends the commit value,
// and owns the 32x32 GPR file plus a retired-instruction counter.
// Optional macro WB_BYPASS_EN forwards the same-cycle commit onto the read ports.
module wb_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins_w,
    input  logic [31:0] ao_w,
    input  logic [1:0]  byte_addr_w,
    input  logic [31:0] rd_w,
    input  logic [31:0] hi_w,
    input  logic [31:0] lo_w,
    input  logic [31:0] pc8_w,
    input  logic [31:0] cp0_rd_w,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] commit_cnt
);

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] regs [32];
    logic [31:0] byte_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        dec_en;
    logic        unused_shamt;

    assign op    = ins_w[31:26];
    assign rs    = ins_w[25:21];
    assign rt    = ins_w[20:16];
    assign rd    = ins_w[15:11];
    assign funct = ins_w[5:0];
    assign unused_shamt = ^ins_w[10:6];

    // Halfword select uses only the upper address bit; bit 0 is ignored.
    assign byte_sh = rd_w >> {byte_addr_w, 3'b000};
    assign ld_byte = byte_sh[7:0];
    assign ld_half = byte_addr_w[1] ? rd_w[31:16] : rd_w[15:0];

    always_comb begin
        dec_en  = 1'b0;
        wb_addr = 5'd0;
        wb_data = 32'd0;
        case (op)
            6'h00: begin
                wb_addr = rd;
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: begin dec_en = 1'b1; wb_data = ao_w;  end
                    6'h10:        begin dec_en = 1'b1; wb_data = hi_w;  end
                    6'h12:        begin dec_en = 1'b1; wb_data = lo_w;  end
                    6'h09:        begin dec_en = 1'b1; wb_data = pc8_w; end
                    default: ;
                endcase
            end
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                dec_en = 1'b1; wb_addr = rt; wb_data = ao_w;
            end
            6'h03: begin dec_en = 1'b1; wb_addr = 5'd31; wb_data = pc8_w; end
            6'h10: begin
                wb_addr = rt;
                if (rs == 5'd0) begin dec_en = 1'b1; wb_data = cp0_rd_w; end
            end
            6'h23: begin dec_en = 1'b1; wb_addr = rt; wb_data = rd_w; end
            6'h20: begin dec_en = 1'b1; wb_addr = rt; wb_data = {{24{ld_byte[7]}}, ld_byte}; end
            6'h24: begin dec_en = 1'b1; wb_addr = rt; wb_data = {24'd0, ld_byte}; end
            6'h21: begin dec_en = 1'b1; wb_addr = rt; wb_data = {{16{ld_half[15]}}, ld_half}; end
            6'h25: begin dec_en = 1'b1; wb_addr = rt; wb_data = {16'd0, ld_half}; end
            default: ;
        endcase
    end

    assign wb_en = dec_en && (wb_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)              commit_cnt <= 32'd0;
        else if (ins_w != 32'd0) commit_cnt <= commit_cnt + 32'd1;
    end

    // Register 0 is masked on read so it is zero even before the first reset.
`ifdef WB_BYPASS_EN
    assign rs_data = (rs_addr == 5'd0) ? 32'd0 :
                     (wb_en && rs_addr == wb_addr) ? wb_data : regs[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? 32'd0 :
                     (wb_en && rt_addr == wb_addr) ? wb_data : regs[rt_addr];
`else
    assign rs_data = (rs_addr == 5'd0) ? 32'd0 : regs[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? 32'd0 : regs[rt_addr];
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expected commits queued at drive time, popped at sample time.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ins_w, ao_w, rd_w, hi_w, lo_w, pc8_w, cp0_rd_w;
    logic [1:0]  byte_addr_w;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data, wb_data, commit_cnt;
    logic        wb_en;
    logic [4:0]  wb_addr;

    wb_regfile dut (
        .clk(clk), .reset(reset), .ins_w(ins_w), .ao_w(ao_w), .byte_addr_w(byte_addr_w),
        .rd_w(rd_w), .hi_w(hi_w), .lo_w(lo_w), .pc8_w(pc8_w), .cp0_rd_w(cp0_rd_w),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins, ao, pc8;
        logic [1:0]  ba;
        logic        en;
        logic [4:0]  a;
        logic [31:0] d;
    } vec_t;

    typedef struct {
        logic        en;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    localparam logic [31:0] HI  = 32'h4848_4848;
    localparam logic [31:0] LO  = 32'h1010_1010;
    localparam logic [31:0] CP0 = 32'hC0C0_0001;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mdl [32];
    logic [31:0] mcnt;
    exp_t        sb [$];
    vec_t        vecs [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input exp_t e);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (e.en && a == e.a) return e.d;
`endif
        return mdl[a];
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        ins_w = v.ins; ao_w = v.ao; pc8_w = v.pc8; byte_addr_w = v.ba;
        rs_addr = v.a; rt_addr = 5'd8;
        sb.push_back('{en: v.en, a: v.a, d: v.d});
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("wb_en", {31'd0, wb_en}, {31'd0, e.en});
        if (e.en) begin
            chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.a});
            chk("wb_data", wb_data, e.d);
        end
        chk("rs_pre", rs_data, exp_rd(rs_addr, e));
        chk("rt_pre", rt_data, exp_rd(rt_addr, e));
        @(posedge clk);
        if (e.en) mdl[e.a] = e.d;
        if (v.ins != 32'd0) mcnt = mcnt + 32'd1;
        #1 ins_w = 32'd0;
        #1;
        chk("rs_post", rs_data, mdl[v.a]);
        chk("cnt", commit_cnt, mcnt);
    endtask

    initial begin
        reset = 1'b1; ins_w = '0; ao_w = '0; byte_addr_w = '0;
        rd_w = 32'h80FF_7F01; hi_w = HI; lo_w = LO; pc8_w = '0; cp0_rd_w = CP0;
        rs_addr = '0; rt_addr = '0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mcnt = 32'd0;

        vecs.push_back('{32'h3C08_1234, 32'h1234_0000, 32'h0, 2'd0, 1'b1, 5'd8,  32'h1234_0000});
        vecs.push_back('{32'h8009_0000, 32'h0, 32'h0, 2'd2, 1'b1, 5'd9,  32'hFFFF_FFFF});
        vecs.push_back('{32'h9009_0000, 32'h0, 32'h0, 2'd2, 1'b1, 5'd9,  32'h0000_00FF});
        vecs.push_back('{32'h8409_0000, 32'h0, 32'h0, 2'd3, 1'b1, 5'd9,  32'hFFFF_80FF});
        vecs.push_back('{32'h9409_0000, 32'h0, 32'h0, 2'd1, 1'b1, 5'd9,  32'h0000_7F01});
        vecs.push_back('{32'h800A_0000, 32'h0, 32'h0, 2'd3, 1'b1, 5'd10, 32'hFFFF_FF80});
        vecs.push_back('{32'h900A_0000, 32'h0, 32'h0, 2'd1, 1'b1, 5'd10, 32'h0000_007F});
        vecs.push_back('{32'h8C0B_0000, 32'h0, 32'h0, 2'd0, 1'b1, 5'd11, 32'h80FF_7F01});
        vecs.push_back('{32'h0000_0021, 32'hDEAD_BEEF, 32'h0, 2'd0, 1'b0, 5'd0, 32'h0});
        vecs.push_back('{32'h0000_6021, 32'hDEAD_BEEF, 32'h0, 2'd0, 1'b1, 5'd12, 32'hDEAD_BEEF});
        vecs.push_back('{32'h0000_6810, 32'h0, 32'h0, 2'd0, 1'b1, 5'd13, HI});
        vecs.push_back('{32'h0000_7012, 32'h0, 32'h0, 2'd0, 1'b1, 5'd14, LO});
        vecs.push_back('{32'h0000_7809, 32'h0, 32'h0000_1008, 2'd0, 1'b1, 5'd15, 32'h0000_1008});
        vecs.push_back('{32'h4010_0000, 32'h0, 32'h0, 2'd0, 1'b1, 5'd16, CP0});
        vecs.push_back('{32'h4090_0000, 32'h0, 32'h0, 2'd0, 1'b0, 5'd16, 32'h0});
        vecs.push_back('{32'hAC11_0000, 32'h5555, 32'h0, 2'd0, 1'b0, 5'd17, 32'h0});
        vecs.push_back('{32'h1111_0000, 32'h5555, 32'h0, 2'd0, 1'b0, 5'd17, 32'h0});
        vecs.push_back('{32'h3412_5555, 32'h0000_5555, 32'h0, 2'd0, 1'b1, 5'd18, 32'h0000_5555});
        vecs.push_back('{32'h0000_982A, 32'h1, 32'h0, 2'd0, 1'b1, 5'd19, 32'h1});
        vecs.push_back('{32'h0000_A018, 32'h77, 32'h0, 2'd0, 1'b0, 5'd20, 32'h0});
        vecs.push_back('{32'h0000_0000, 32'h99, 32'h0, 2'd0, 1'b0, 5'd8, 32'h0});
        vecs.push_back('{32'h0C00_0100, 32'h0, 32'h0000_2000, 2'd0, 1'b1, 5'd31, 32'h0000_2000});
        vecs.push_back('{32'h0C00_0100, 32'h0, 32'h0000_3008, 2'd0, 1'b1, 5'd31, 32'h0000_3008});
        vecs.push_back('{32'h3C00_FFFF, 32'hFFFF_0000, 32'h0, 2'd0, 1'b0, 5'd0, 32'h0});

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = i[4:0]; rt_addr = 5'(31 - i);
            #1;
            chk("rst_rs", rs_data, 32'd0);
            chk("rst_rt", rt_data, 32'd0);
        end
        chk("rst_cnt", commit_cnt, 32'd0);
        @(posedge clk); #1;

        foreach (vecs[k]) run_vec(vecs[k]);

        // Reset arriving with a load in W must drop that commit.
        ins_w = 32'h8C15_0000; byte_addr_w = 2'd0; reset = 1'b1;
        rs_addr = 5'd21; rt_addr = 5'd8;
        @(posedge clk);
        #1 reset = 1'b0; ins_w = 32'd0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mcnt = 32'd0;
        #1;
        chk("rstp_rs21", rs_data, 32'd0);
        chk("rstp_rt8", rt_data, 32'd0);
        chk("rstp_cnt", commit_cnt, 32'd0);

        run_vec(vecs[0]);
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have port: clk  in  1  clock, rising edge.
REQ-002 SHALL have port: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: ins_w  in  32  instruction held in W stage; 0 = bubble.
REQ-004 SHALL have port: ao_w  in  32  ALU result.
REQ-005 SHALL have port: byte_addr_w  in  2  low address bits of load.
REQ-006 SHALL have port: rd_w  in  32  raw data-memory word.
REQ-007 SHALL have ports: hi_w, lo_w  in  32  HI/LO values; pc8_w  in  32  link address; cp0_rd_w  in  32  CP0 read data.
REQ-008 SHALL have ports: rs_addr, rt_addr  in  5  read addresses; rs_data, rt_data  out  32  read data.
REQ-009 SHALL have ports: wb_en  out  1; wb_addr  out  5; wb_data  out  32  current-cycle commit.
REQ-010 SHALL have port: commit_cnt  out  32  retired non-bubble instructions.

Function
REQ-011 SHALL decode ins_w combinationally: op=ins_w[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
REQ-012 SHALL target rd with ao_w for op 0x00 and funct in {00,02,03,04,06,07,21,23,24,25,26,27,2A,2B}.
REQ-013 SHALL target rt with ao_w for op in {09,0A,0B,0C,0D,0E,0F}.
REQ-014 SHALL target rd with hi_w for op 0x00/funct 0x10, lo_w for funct 0x12, pc8_w for funct 0x09 (jalr).
REQ-015 SHALL target register 31 with pc8_w for op 0x03 (jal); target rt with cp0_rd_w for op 0x10, rs=0x00 (mfc0).
REQ-016 SHALL target rt with load data: 0x23 lw = rd_w; 0x20 lb / 0x24 lbu = byte rd_w[8*byte_addr_w+:8] sign/zero-extended; 0x21 lh / 0x25 lhu = half rd_w[16*byte_addr_w[1]+:16] sign/zero-extended; byte_addr_w[0] ignored for halfwords.
REQ-017 SHALL drive wb_en=1 only when a write is decoded and target != 0; all other opcodes produce wb_en=0.
REQ-018 SHALL write wb_data into register wb_addr on the rising edge when wb_en=1; register 0 never written, always reads 0.
REQ-019 SHALL provide combinational rs_data/rt_data from the 32x32 array.
REQ-020 SHALL increment commit_cnt by 1 each edge with ins_w != 0, wrapping 0xFFFFFFFF -> 0.
REQ-021 SHALL process one instruction per cycle, zero stall, commit latency one edge.

Reset
REQ-022 SHALL, on reset=1 at a rising edge, clear all 32 registers and commit_cnt to 0, suppressing any write that edge.
REQ-023 SHALL leave wb_en/wb_addr/wb_data combinational from inputs (not reset-gated); reset mid-stream discards the concurrent commit.

Configuration
REQ-024 SHALL honour macro WB_BYPASS_EN.
REQ-025 SHALL, with WB_BYPASS_EN defined, return wb_data on rs_data/rt_data when wb_en=1 and the read address equals wb_addr (nonzero).
REQ-026 SHALL, without WB_BYPASS_EN, return the pre-edge stored value in that case.

Verification
REQ-027 Reset, then read all 32 addresses -> every rs_data/rt_data = 0, commit_cnt = 0.
REQ-028 ins_w=0x3C08_1234 (lui $8), ao_w=0x1234_0000 -> wb_en=1, wb_addr=8; after edge reading 8 = 0x1234_0000, commit_cnt=1.
REQ-029 lb $9 (0x8009_0000), rd_w=0x80FF_7F01, byte_addr_w=2 -> wb_data=0xFFFF_FFFF; lbu -> 0x0000_00FF; lh, byte_addr_w=3 -> 0xFFFF_80FF.
REQ-030 addu $0 (0x0000_0021), ao_w=0xDEAD_BEEF -> wb_en=0, register 0 reads 0; ins_w=0 -> commit_cnt unchanged.
REQ-031 jal, pc8_w=0x0000_3008, rs_addr=31 same cycle -> with WB_BYPASS_EN rs_data=0x3008 pre-edge, without it old value; both 0x3008 after edge.
REQ-032 commit_cnt forced to 0xFFFF_FFFF via 2^32-1 commits (or shortened test build), one more non-bubble -> 0; reset asserted with lw pending -> target stays 0.
